rpi_inst_issuer: RTL

SPI-slave front end that receives N-bit task instructions from the Raspberry Pi and issues them to the accelerator's task manager. It deserializes one instruction per chip-select frame and presents it on `RPi_inst`. It then performs the `execute_task` / `job_done` handshake and returns a status byte to the Pi on MISO. It sits between the board GPIO/SPI pins and the task manager.

---
 rtl/rpi_inst_issuer_pkg.sv | 24 ++
 rtl/rpi_inst_issuer_spi_sync_edge.sv | 29 ++
 rtl/rpi_inst_issuer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rpi_inst_issuer_pkg.sv
// Shared types and constants for the Raspberry Pi instruction issuer.
package rpi_accel_pkg;

    localparam int DEFAULT_N = 80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_e;

    // Bit positions inside the status byte returned on MISO.
    localparam int STAT_JOB_DONE   = 7;
    localparam int STAT_INST_VALID = 6;
    localparam int STAT_BUSY       = 5;
    localparam int STAT_FRAME_ERR  = 4;
    localparam int STAT_REJECT     = 3;
    localparam int STAT_OVERRUN    = 2;
    localparam int STAT_TIMEOUT    = 1;
    localparam int STAT_ONE        = 0;

endpackage

// File: rtl/rpi_inst_issuer_spi_sync_edge.sv
// 2-FF synchronizer with registered rise/fall pulses; level is delayed to line up with the pulses.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RESET_VAL}};
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], din};
            rise   <= sync_q[1] & ~sync_q[2];
            fall   <= ~sync_q[1] & sync_q[2];
        end
    end

    assign level = sync_q[2];

endmodule

// File: rtl/rpi_inst_issuer.sv
// SPI-slave instruction receiver and task-manager issue handshake.
// Optional watchdog: define RPI_INST_ISSUER_TIMEOUT_EN.
module rpi_inst_issuer
    import rpi_accel_pkg::*;
#(
    parameter int N              = DEFAULT_N,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    output logic [N-1:0] RPi_inst,
    output logic         execute_task,
    input  logic         inst_valid,
    input  logic         job_done,
    output logic         busy
);

    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] CNT_N   = CW'(N);
    localparam logic [CW-1:0] CNT_SAT = CW'(N + 1);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_e          state_q, state_d;
    logic [N-1:0]    rx_q, rx_d, inst_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      tx_q, status;
    logic            last_valid_q, ferr_q, rej_q, ovr_q, tmo;
    logic            frame_active, frame_full, accept;
    logic            set_ferr, set_ovr, set_rej;

    // The closing sclk edge may land in the same cycle as cs_rise, so it still counts.
    assign frame_active = ~cs_lvl | cs_rise;

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        rx_d  = rx_q;
        cnt_d = cnt_q;
        if (sclk_rise && frame_active) begin
            rx_d = {rx_q[N-2:0], mosi_lvl};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
        if (cs_fall) cnt_d = '0;
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_full = cs_rise && (cnt_d == CNT_N);
    assign accept     = frame_full && !busy;
    assign set_ferr   = cs_rise && (cnt_d != CNT_N);
    assign set_ovr    = frame_full && busy;
    assign set_rej    = (state_q == ST_CHECK) && !inst_valid;

    assign status = {job_done, last_valid_q, busy, ferr_q, rej_q, ovr_q, tmo, 1'b1};

`ifdef RPI_INST_ISSUER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q;
    logic           waiting, timeout_hit, tmo_q;

    assign waiting     = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE);
    assign timeout_hit = waiting && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q <= waiting ? wd_q + 1'b1 : '0;
            if (cs_fall)     tmo_q <= 1'b0;
            if (timeout_hit) tmo_q <= 1'b1;
        end
    end
    assign tmo = tmo_q;
`else
    localparam bit TIMEOUT_UNUSED = (TIMEOUT_CYCLES > 0);
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        execute_task = 1'b0;
        case (state_q)
            ST_IDLE:      if (accept) state_d = ST_CHECK;
            ST_CHECK:     state_d = inst_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: begin
                if (job_done) begin
                    execute_task = 1'b1;
                    state_d      = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK:  if (!job_done) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (job_done) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
`ifdef RPI_INST_ISSUER_TIMEOUT_EN
        if (timeout_hit) begin
            state_d      = ST_IDLE;
            execute_task = 1'b0;
        end
`endif
    end

    // NOTE: the shift registers are plain flops, so they reset with everything else; nothing stale survives a mid-frame reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rx_q         <= '0;
            cnt_q        <= '0;
            tx_q         <= '0;
            inst_q       <= '0;
            last_valid_q <= 1'b0;
            ferr_q       <= 1'b0;
            rej_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;

            if (cs_fall)
                tx_q <= status;
            else if (sclk_fall && !cs_lvl)
                tx_q <= {tx_q[6:0], 1'b0};

            if (accept) inst_q <= rx_d;
            if (state_q == ST_CHECK) last_valid_q <= inst_valid;

            // Read-to-clear: a set in the same cycle as cs_fall overrides the clear.
            if (cs_fall) begin
                ferr_q <= 1'b0;
                rej_q  <= 1'b0;
                ovr_q  <= 1'b0;
            end
            if (set_ferr) ferr_q <= 1'b1;
            if (set_rej)  rej_q  <= 1'b1;
            if (set_ovr)  ovr_q  <= 1'b1;
        end
    end

    assign miso     = tx_q[7];
    assign RPi_inst = inst_q;

endmodule
